// File: rtl/cva6_bht_lhist_if.sv
`default_nettype none
// ============================================================================
// Module      : cva6_bht_lhist_if
// Description : Lookup / training bus between the frontend and the
//               local-history BHT.
// Revision    : 1.0 - initial release
// ============================================================================
interface cva6_bht_lhist_if #(
    parameter int VLEN = 32
);
    logic            flush_i;
    logic            debug_mode_i;
    logic [VLEN-1:0] vpc_i;
    logic            upd_valid_i;
    logic [VLEN-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic            pred_valid_o;
    logic            pred_taken_o;

    modport master (
        output flush_i, debug_mode_i, vpc_i, upd_valid_i, upd_pc_i, upd_taken_i,
        input  pred_valid_o, pred_taken_o
    );

    modport slave (
        input  flush_i, debug_mode_i, vpc_i, upd_valid_i, upd_pc_i, upd_taken_i,
        output pred_valid_o, pred_taken_o
    );
endinterface
`default_nettype wire

// File: rtl/cva6_bht_lhist.sv
`default_nettype none
// ============================================================================
// Module      : cva6_bht_lhist
// Description : Untagged local-history branch history table; each entry keeps
//               a history shift register selecting one of 2^HIST_LEN counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cva6_bht_lhist #(
    parameter int NR_ENTRIES = 32,
    parameter int HIST_LEN   = 3,
    parameter int VLEN       = 32,
    parameter int PC_OFFSET  = 1
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    cva6_bht_lhist_if.slave   bht
);
    localparam int c_idx_w   = $clog2(NR_ENTRIES);
    localparam int c_nr_ctrs = 2 ** HIST_LEN;

    logic                 r_valid [NR_ENTRIES];
    logic [HIST_LEN-1:0]  r_hist  [NR_ENTRIES];
    logic [1:0]           r_ctr   [NR_ENTRIES][c_nr_ctrs];

    logic [c_idx_w-1:0]   w_lk_idx;
    logic [c_idx_w-1:0]   w_upd_idx;
    logic [HIST_LEN-1:0]  w_upd_hist;
    logic [HIST_LEN-1:0]  w_hist_next;
    logic [1:0]           w_ctr_cur;
    logic [1:0]           w_ctr_next;
    logic                 w_upd_en;
    logic                 w_unused;

    assign w_lk_idx   = bht.vpc_i[PC_OFFSET +: c_idx_w];
    assign w_upd_idx  = bht.upd_pc_i[PC_OFFSET +: c_idx_w];
    assign w_upd_hist = r_hist[w_upd_idx];
    assign w_ctr_cur  = r_ctr[w_upd_idx][w_upd_hist];
    assign w_upd_en   = bht.upd_valid_i & ~bht.debug_mode_i;

    // Only the index slice of each PC is consumed; fold the rest away.
    assign w_unused = ^{bht.vpc_i, bht.upd_pc_i};

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (bht.upd_taken_i) begin
            if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
        end
    end

    generate
        if (HIST_LEN == 1) begin : g_hist_single
            assign w_hist_next = bht.upd_taken_i;
        end else begin : g_hist_shift
            assign w_hist_next = {w_upd_hist[HIST_LEN-2:0], bht.upd_taken_i};
        end
    endgenerate

    // Flush shares the reset path, so a same-cycle update is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i || bht.flush_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_hist[i]  <= '0;
                for (int j = 0; j < c_nr_ctrs; j++) begin
                    r_ctr[i][j] <= 2'b01;
                end
            end
        end else if (w_upd_en) begin
            r_valid[w_upd_idx]             <= 1'b1;
            r_hist[w_upd_idx]              <= w_hist_next;
            r_ctr[w_upd_idx][w_upd_hist]   <= w_ctr_next;
        end
    end

    assign bht.pred_valid_o = r_valid[w_lk_idx];
    assign bht.pred_taken_o = r_valid[w_lk_idx] & r_ctr[w_lk_idx][r_hist[w_lk_idx]][1];

endmodule
`default_nettype wire

// File: tb/tb_cva6_bht_lhist.sv
`default_nettype none
// ============================================================================
// Module      : tb_cva6_bht_lhist
// Description : Directed bench for the local-history BHT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cva6_bht_lhist;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cva6_bht_lhist_if #(.VLEN(32)) bht_if ();

    cva6_bht_lhist #(
        .NR_ENTRIES (32),
        .HIST_LEN   (3),
        .VLEN       (32),
        .PC_OFFSET  (1)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bht   (bht_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic upd(input logic [31:0] pc, input logic taken);
        bht_if.upd_valid_i = 1'b1;
        bht_if.upd_pc_i    = pc;
        bht_if.upd_taken_i = taken;
        @(posedge clk);
        #1;
        bht_if.upd_valid_i = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic ev, input logic et);
        bht_if.vpc_i = pc;
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, bht_if.pred_valid_o}, {31'd0, ev});
        chk({tag, "_taken"}, {31'd0, bht_if.pred_taken_o}, {31'd0, et});
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] PC8  = 32'h8000_0010;
    localparam logic [31:0] PC8A = 32'h8000_0050;
    localparam logic [31:0] PC9  = 32'h8000_0012;
    localparam logic [31:0] PC4  = 32'h8000_0008;
    localparam logic [31:0] PC3  = 32'h8000_0006;
    localparam logic [31:0] PC5  = 32'h8000_000A;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bht_if.flush_i      = 1'b0;
        bht_if.debug_mode_i = 1'b0;
        bht_if.vpc_i        = '0;
        bht_if.upd_valid_i  = 1'b0;
        bht_if.upd_pc_i     = '0;
        bht_if.upd_taken_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            look($sformatf("reset_sweep%0d", i), 32'h8000_0000 | (i << 1), 1'b0, 1'b0);
        end

        // Three taken: hist 111, ctr[111] still weakly not-taken.
        repeat (3) upd(PC8, 1'b1);
        look("train3", PC8, 1'b1, 1'b0);
        upd(PC8, 1'b1);
        look("train4", PC8, 1'b1, 1'b1);
        // Six more taken: ctr[111] must saturate at 11 rather than wrap.
        repeat (6) upd(PC8, 1'b1);
        look("saturate", PC8, 1'b1, 1'b1);
        upd(PC8, 1'b0);
        look("not_taken", PC8, 1'b1, 1'b0);
        // Walk hist back to 111; ctr[111] must now read 10.
        repeat (3) upd(PC8, 1'b1);
        look("back_to_111", PC8, 1'b1, 1'b1);

        look("alias", PC8A, 1'b1, 1'b1);
        look("neighbour", PC9, 1'b0, 1'b0);

        // Same-cycle lookup sees old state; new state one cycle later.
        bht_if.vpc_i       = PC4;
        bht_if.upd_valid_i = 1'b1;
        bht_if.upd_pc_i    = PC4;
        bht_if.upd_taken_i = 1'b1;
        @(negedge clk);
        chk("same_cycle_valid", {31'd0, bht_if.pred_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        bht_if.upd_valid_i = 1'b0;
        look("next_cycle", PC4, 1'b1, 1'b0);

        // Flush with a simultaneous update.
        bht_if.flush_i = 1'b1;
        upd(PC3, 1'b1);
        bht_if.flush_i = 1'b0;
        look("flush_idx3", PC3, 1'b0, 1'b0);
        look("flush_idx8", PC8, 1'b0, 1'b0);
        look("flush_idx4", PC4, 1'b0, 1'b0);

        bht_if.debug_mode_i = 1'b1;
        upd(PC5, 1'b1);
        bht_if.debug_mode_i = 1'b0;
        look("debug_idx5", PC5, 1'b0, 1'b0);

        // Train, then reset with an update presented during reset.
        repeat (4) upd(PC8, 1'b1);
        look("pre_reset", PC8, 1'b1, 1'b1);
        rst = 1'b1;
        upd(PC8, 1'b1);
        rst = 1'b0;
        look("post_reset", PC8, 1'b0, 1'b0);
        upd(PC8, 1'b1);
        look("retrain", PC8, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
